// File: rtl/cpu_regfile_n.sv
// Parametrised CPU register file: two combinational read ports, one write port, and a step port
// with registered zero/carry flags. Define CPU_REGFILE_SHADOW_EN to add a swappable shadow bank.
module cpu_regfile_n #(
    parameter int unsigned DATA_W   = 8,
    parameter int unsigned NUM_REGS = 4,
    parameter int unsigned ADDR_W   = 2
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [ADDR_W-1:0] raddr_a_i,
    output logic [DATA_W-1:0] rdata_a_o,
    input  logic [ADDR_W-1:0] raddr_b_i,
    output logic [DATA_W-1:0] rdata_b_o,
    input  logic              step_en_i,
    input  logic [ADDR_W-1:0] step_addr_i,
    input  logic              step_dec_i,
    output logic              step_zero_o,
    output logic              step_carry_o,
    input  logic              bank_swap_i,
    output logic              bank_o
);

`ifdef CPU_REGFILE_SHADOW_EN
    localparam int unsigned NUM_BANKS = 2;
`else
    localparam int unsigned NUM_BANKS = 1;
`endif
    localparam int unsigned NUM_SLOTS = NUM_BANKS * NUM_REGS;
    localparam int unsigned SUM_W     = DATA_W + 1;

    // Elaboration-time parameter sanity
    if (DATA_W < 2) begin : g_bad_width
        $error("cpu_regfile_n: DATA_W must be at least 2");
    end
    if (NUM_REGS < 2 || NUM_REGS > (1 << ADDR_W)) begin : g_bad_regs
        $error("cpu_regfile_n: NUM_REGS must be in 2..2**ADDR_W");
    end

    logic [DATA_W-1:0] regs_q [NUM_SLOTS];
    logic [DATA_W-1:0] regs_d [NUM_SLOTS];
    logic              zero_q, zero_d;
    logic              carry_q, carry_d;
    logic              bank_q, bank_d;

    logic              wr_ok;
    logic              step_ok;
    logic [DATA_W-1:0] step_cur;
    logic [SUM_W-1:0]  step_sum;

`ifndef CPU_REGFILE_SHADOW_EN
    logic unused_bank_swap;
    assign unused_bank_swap = bank_swap_i;
`endif

    // Read ports: slot s belongs to bank s/NUM_REGS, register s%NUM_REGS; out-of-range never matches
    always_comb begin
        rdata_a_o = '0;
        rdata_b_o = '0;
        for (int unsigned s = 0; s < NUM_SLOTS; s++) begin
            if ((s / NUM_REGS) == 32'(bank_q)) begin
                if (32'(raddr_a_i) == (s % NUM_REGS)) begin
                    rdata_a_o = regs_q[s];
                end
                if (32'(raddr_b_i) == (s % NUM_REGS)) begin
                    rdata_b_o = regs_q[s];
                end
            end
        end
    end

    // Qualify requests; a write to the same register cancels the step
    always_comb begin
        wr_ok   = we_i && (32'(waddr_i) < NUM_REGS);
        step_ok = step_en_i && (32'(step_addr_i) < NUM_REGS)
                  && !(wr_ok && (waddr_i == step_addr_i));
    end

    // Step arithmetic in DATA_W+1 bits so the top bit is the wrap indication
    always_comb begin
        step_cur = '0;
        for (int unsigned s = 0; s < NUM_SLOTS; s++) begin
            if (((s / NUM_REGS) == 32'(bank_q)) && (32'(step_addr_i) == (s % NUM_REGS))) begin
                step_cur = regs_q[s];
            end
        end
        if (step_dec_i) begin
            step_sum = {1'b0, step_cur} - SUM_W'(1);
        end else begin
            step_sum = {1'b0, step_cur} + SUM_W'(1);
        end
    end

    // Next state for storage, flags and bank; all updates target the pre-swap bank
    always_comb begin
        regs_d  = regs_q;
        zero_d  = zero_q;
        carry_d = carry_q;
        bank_d  = bank_q;
        for (int unsigned s = 0; s < NUM_SLOTS; s++) begin
            if ((s / NUM_REGS) == 32'(bank_q)) begin
                if (step_ok && (32'(step_addr_i) == (s % NUM_REGS))) begin
                    regs_d[s] = step_sum[DATA_W-1:0];
                end
                if (wr_ok && (32'(waddr_i) == (s % NUM_REGS))) begin
                    regs_d[s] = wdata_i;
                end
            end
        end
        if (step_ok) begin
            zero_d  = (step_sum[DATA_W-1:0] == '0);
            carry_d = step_sum[DATA_W];
        end
`ifdef CPU_REGFILE_SHADOW_EN
        bank_d = bank_q ^ bank_swap_i;
`else
        bank_d = 1'b0;
`endif
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int unsigned s = 0; s < NUM_SLOTS; s++) begin
                regs_q[s] <= '0;
            end
            zero_q  <= 1'b0;
            carry_q <= 1'b0;
            bank_q  <= 1'b0;
        end else begin
            regs_q  <= regs_d;
            zero_q  <= zero_d;
            carry_q <= carry_d;
            bank_q  <= bank_d;
        end
    end

    assign step_zero_o  = zero_q;
    assign step_carry_o = carry_q;
    assign bank_o       = bank_q;

endmodule

// File: tb/tb_cpu_regfile_n.sv
// Bench for cpu_regfile_n: directed scenarios plus randomized traffic against an array-based model.
// Define CPU_REGFILE_SHADOW_EN for both files to exercise the shadow bank.
module tb_cpu_regfile_n;
    localparam int unsigned DATA_W   = 8;
    localparam int unsigned NUM_REGS = 4;
    localparam int unsigned ADDR_W   = 3;

    logic              clk_i;
    logic              rst_ni;
    logic              we_i;
    logic [ADDR_W-1:0] waddr_i;
    logic [DATA_W-1:0] wdata_i;
    logic [ADDR_W-1:0] raddr_a_i;
    logic [DATA_W-1:0] rdata_a_o;
    logic [ADDR_W-1:0] raddr_b_i;
    logic [DATA_W-1:0] rdata_b_o;
    logic              step_en_i;
    logic [ADDR_W-1:0] step_addr_i;
    logic              step_dec_i;
    logic              step_zero_o;
    logic              step_carry_o;
    logic              bank_swap_i;
    logic              bank_o;

    int checks = 0;
    int passes = 0;

    // Reference model: plain per-bank arrays and flag bits
    logic [DATA_W-1:0] m_regs [2][NUM_REGS];
    int                m_bank;
    bit                m_zero;
    bit                m_carry;

    cpu_regfile_n #(.DATA_W(DATA_W), .NUM_REGS(NUM_REGS), .ADDR_W(ADDR_W)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .we_i(we_i), .waddr_i(waddr_i), .wdata_i(wdata_i),
        .raddr_a_i(raddr_a_i), .rdata_a_o(rdata_a_o), .raddr_b_i(raddr_b_i), .rdata_b_o(rdata_b_o),
        .step_en_i(step_en_i), .step_addr_i(step_addr_i), .step_dec_i(step_dec_i),
        .step_zero_o(step_zero_o), .step_carry_o(step_carry_o),
        .bank_swap_i(bank_swap_i), .bank_o(bank_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    function automatic logic [DATA_W-1:0] m_read(input logic [ADDR_W-1:0] a);
        if (int'(a) >= int'(NUM_REGS)) return '0;
        return m_regs[m_bank][int'(a)];
    endfunction

    task automatic model_reset();
        for (int b = 0; b < 2; b++)
            for (int r = 0; r < int'(NUM_REGS); r++) m_regs[b][r] = '0;
        m_bank = 0; m_zero = 0; m_carry = 0;
    endtask

    task automatic model_apply();
        int b, old, nv, top;
        bit wv, sv;
        b   = m_bank;
        top = (1 << DATA_W) - 1;
        wv  = we_i && (int'(waddr_i) < int'(NUM_REGS));
        sv  = step_en_i && (int'(step_addr_i) < int'(NUM_REGS)) && !(wv && waddr_i == step_addr_i);
        if (sv) begin
            old = int'(m_regs[b][int'(step_addr_i)]);
            nv  = (old + (step_dec_i ? top : 1)) % (top + 1);
            m_carry = step_dec_i ? (old == 0) : (old == top);
            m_zero  = (nv == 0);
            m_regs[b][int'(step_addr_i)] = DATA_W'(nv);
        end
        if (wv) m_regs[b][int'(waddr_i)] = wdata_i;
`ifdef CPU_REGFILE_SHADOW_EN
        if (bank_swap_i) m_bank = 1 - m_bank;
`endif
    endtask

    task automatic idle();
        we_i = 0; waddr_i = '0; wdata_i = '0;
        step_en_i = 0; step_addr_i = '0; step_dec_i = 0; bank_swap_i = 0;
    endtask

    task automatic tick();
        @(posedge clk_i);
        if (rst_ni) model_apply();
        #1;
    endtask

    task automatic do_reset();
        idle();
        rst_ni = 0;
        model_reset();
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        rst_ni = 1;
        #1;
    endtask

    task automatic wr(input int a, input int d);
        idle(); we_i = 1; waddr_i = ADDR_W'(a); wdata_i = DATA_W'(d);
        tick(); idle();
    endtask

    task automatic stp(input int a, input bit dec);
        idle(); step_en_i = 1; step_addr_i = ADDR_W'(a); step_dec_i = dec;
        tick(); idle();
    endtask

    task automatic test_reset();
        do_reset();
        raddr_a_i = 3'd1; raddr_b_i = 3'd3; #1;
        checks++; if (rdata_a_o !== 8'h00) $display("FAIL reset_rd_a: got %h want 00", rdata_a_o); else passes++;
        checks++; if (rdata_b_o !== 8'h00) $display("FAIL reset_rd_b: got %h want 00", rdata_b_o); else passes++;
        checks++; if ({step_zero_o, step_carry_o, bank_o} !== 3'b000)
            $display("FAIL reset_flags: got %b want 000", {step_zero_o, step_carry_o, bank_o}); else passes++;
    endtask

    task automatic test_write_read();
        do_reset();
        raddr_a_i = 3'd1; raddr_b_i = 3'd3;
        we_i = 1; waddr_i = 3'd1; wdata_i = 8'h5A; #1;
        checks++; if (rdata_a_o !== 8'h00) $display("FAIL no_bypass: got %h want 00", rdata_a_o); else passes++;
        tick(); idle();
        checks++; if (rdata_a_o !== 8'h5A) $display("FAIL wr_r1: got %h want 5a", rdata_a_o); else passes++;
        wr(3, 'hC3);
        checks++; if (rdata_b_o !== 8'hC3) $display("FAIL wr_r3: got %h want c3", rdata_b_o); else passes++;
        raddr_a_i = 3'd0; raddr_b_i = 3'd2; #1;
        checks++; if ({rdata_a_o, rdata_b_o} !== 16'h0000)
            $display("FAIL r0_r2_zero: got %h want 0000", {rdata_a_o, rdata_b_o}); else passes++;
    endtask

    task automatic test_inc_wrap();
        do_reset();
        raddr_a_i = 3'd2;
        wr(2, 'hFE);
        stp(2, 0);
        checks++; if ({rdata_a_o, step_zero_o, step_carry_o} !== {8'hFF, 2'b00})
            $display("FAIL inc_ff: got %h/%b%b want ff/00", rdata_a_o, step_zero_o, step_carry_o); else passes++;
        stp(2, 0);
        checks++; if ({rdata_a_o, step_zero_o, step_carry_o} !== {8'h00, 2'b11})
            $display("FAIL inc_wrap: got %h/%b%b want 00/11", rdata_a_o, step_zero_o, step_carry_o); else passes++;
        tick();
        checks++; if ({step_zero_o, step_carry_o} !== 2'b11)
            $display("FAIL flag_hold: got %b%b want 11", step_zero_o, step_carry_o); else passes++;
    endtask

    task automatic test_dec_wrap();
        do_reset();
        raddr_a_i = 3'd0;
        wr(0, 'h01);
        stp(0, 1);
        checks++; if ({rdata_a_o, step_zero_o, step_carry_o} !== {8'h00, 2'b10})
            $display("FAIL dec_zero: got %h/%b%b want 00/10", rdata_a_o, step_zero_o, step_carry_o); else passes++;
        stp(0, 1);
        checks++; if ({rdata_a_o, step_zero_o, step_carry_o} !== {8'hFF, 2'b01})
            $display("FAIL dec_wrap: got %h/%b%b want ff/01", rdata_a_o, step_zero_o, step_carry_o); else passes++;
    endtask

    task automatic test_collision();
        do_reset();
        wr(3, 'hFF);
        stp(3, 0);
        wr(1, 'h10);
        raddr_a_i = 3'd1; raddr_b_i = 3'd2;
        we_i = 1; waddr_i = 3'd1; wdata_i = 8'h77; step_en_i = 1; step_addr_i = 3'd1;
        tick(); idle();
        checks++; if ({rdata_a_o, step_zero_o, step_carry_o} !== {8'h77, 2'b11})
            $display("FAIL coll_same: got %h/%b%b want 77/11", rdata_a_o, step_zero_o, step_carry_o); else passes++;
        wr(2, 'h05);
        we_i = 1; waddr_i = 3'd1; wdata_i = 8'h20; step_en_i = 1; step_addr_i = 3'd2;
        tick(); idle();
        checks++; if ({rdata_a_o, rdata_b_o} !== 16'h2006)
            $display("FAIL coll_diff: got %h want 2006", {rdata_a_o, rdata_b_o}); else passes++;
        checks++; if ({step_zero_o, step_carry_o} !== 2'b00)
            $display("FAIL coll_diff_flags: got %b%b want 00", step_zero_o, step_carry_o); else passes++;
    endtask

    task automatic test_range();
        do_reset();
        wr(0, 'h11); wr(3, 'h33);
        stp(0, 1);
        wr(int'(NUM_REGS), 'hEE);
        stp(5, 0);
        raddr_a_i = ADDR_W'(NUM_REGS); raddr_b_i = 3'd7; #1;
        checks++; if ({rdata_a_o, rdata_b_o} !== 16'h0000)
            $display("FAIL oor_read: got %h want 0000", {rdata_a_o, rdata_b_o}); else passes++;
        raddr_a_i = 3'd0; raddr_b_i = 3'd3; #1;
        checks++; if ({rdata_a_o, rdata_b_o} !== 16'h1033)
            $display("FAIL oor_nochange: got %h want 1033", {rdata_a_o, rdata_b_o}); else passes++;
        checks++; if ({step_zero_o, step_carry_o} !== 2'b00)
            $display("FAIL oor_flags: got %b%b want 00", step_zero_o, step_carry_o); else passes++;
    endtask

    task automatic test_async_reset();
        do_reset();
        wr(2, 'hFF);
        stp(2, 0);
        wr(1, 'h42);
        raddr_a_i = 3'd1; raddr_b_i = 3'd2;
        we_i = 1; waddr_i = 3'd3; wdata_i = 8'h9C;
        @(posedge clk_i); model_apply();
        #3 rst_ni = 0;
        model_reset();
        #1;
        checks++; if ({rdata_a_o, rdata_b_o, step_zero_o, step_carry_o, bank_o} !== 19'h0)
            $display("FAIL async_rst: got %h/%h/%b%b%b want 00/00/000",
                     rdata_a_o, rdata_b_o, step_zero_o, step_carry_o, bank_o); else passes++;
        idle();
        @(negedge clk_i); rst_ni = 1; #1;
        raddr_a_i = 3'd3; #1;
        checks++; if (rdata_a_o !== 8'h00) $display("FAIL async_rst_r3: got %h want 00", rdata_a_o); else passes++;
    endtask

    task automatic test_bank();
        do_reset();
        raddr_a_i = 3'd0; raddr_b_i = 3'd1;
        wr(0, 'hAA);
`ifdef CPU_REGFILE_SHADOW_EN
        idle(); bank_swap_i = 1; tick(); idle();
        wr(0, 'h55);
        checks++; if ({rdata_a_o, bank_o} !== {8'h55, 1'b1})
            $display("FAIL shadow_wr: got %h/%b want 55/1", rdata_a_o, bank_o); else passes++;
        bank_swap_i = 1; tick(); idle();
        checks++; if ({rdata_a_o, bank_o} !== {8'hAA, 1'b0})
            $display("FAIL shadow_back: got %h/%b want aa/0", rdata_a_o, bank_o); else passes++;
        bank_swap_i = 1; we_i = 1; waddr_i = 3'd1; wdata_i = 8'h99; tick(); idle();
        checks++; if ({rdata_b_o, bank_o} !== {8'h00, 1'b1})
            $display("FAIL swap_wr_new: got %h/%b want 00/1", rdata_b_o, bank_o); else passes++;
        bank_swap_i = 1; tick(); idle();
        checks++; if ({rdata_b_o, bank_o} !== {8'h99, 1'b0})
            $display("FAIL swap_wr_old: got %h/%b want 99/0", rdata_b_o, bank_o); else passes++;
`else
        bank_swap_i = 1; tick(); idle();
        checks++; if ({rdata_a_o, bank_o} !== {8'hAA, 1'b0})
            $display("FAIL noshadow_swap: got %h/%b want aa/0", rdata_a_o, bank_o); else passes++;
`endif
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 400; i++) begin
            we_i        = ($urandom_range(0, 2) != 0);
            waddr_i     = ADDR_W'($urandom_range(0, 5));
            wdata_i     = DATA_W'($urandom_range(0, 3) == 0 ? (($urandom_range(0, 1) == 1) ? 255 : 0) : $urandom);
            step_en_i   = ($urandom_range(0, 1) == 1);
            step_addr_i = ADDR_W'($urandom_range(0, 5));
            step_dec_i  = ($urandom_range(0, 1) == 1);
            bank_swap_i = ($urandom_range(0, 7) == 0);
            raddr_a_i   = ADDR_W'($urandom_range(0, 7));
            raddr_b_i   = ADDR_W'($urandom_range(0, 5));
            tick();
            checks++; if (rdata_a_o !== m_read(raddr_a_i))
                $display("FAIL rnd_a[%0d]: got %h want %h", i, rdata_a_o, m_read(raddr_a_i)); else passes++;
            checks++; if (rdata_b_o !== m_read(raddr_b_i))
                $display("FAIL rnd_b[%0d]: got %h want %h", i, rdata_b_o, m_read(raddr_b_i)); else passes++;
            checks++; if ({step_zero_o, step_carry_o} !== {m_zero, m_carry})
                $display("FAIL rnd_flags[%0d]: got %b%b want %b%b", i, step_zero_o, step_carry_o, m_zero, m_carry);
            else passes++;
            checks++; if (bank_o !== 1'(m_bank))
                $display("FAIL rnd_bank[%0d]: got %b want %0d", i, bank_o, m_bank); else passes++;
        end
        idle();
    endtask

    initial begin
        rst_ni = 0;
        raddr_a_i = '0; raddr_b_i = '0;
        idle();
        model_reset();
        test_reset();
        test_write_read();
        test_inc_wrap();
        test_dec_wrap();
        test_collision();
        test_range();
        test_async_reset();
        test_bank();
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule

// File: doc/cpu_regfile_n.md
# cpu_regfile_n

Parametrised general-purpose register file for the 8-bit CPU core. It replaces the fixed two-register A/X file.
- Holds NUM_REGS registers of DATA_W bits.
- One synchronous write port and two combinational read ports.
- A dedicated step port that increments or decrements one register per cycle (index/loop-counter use), with registered zero/carry flags.
- An optional shadow bank for single-cycle interrupt context switching.

The block sits between the decode/control unit and the ALU datapath.

## Interface
Parameters:
- DATA_W, 8, register width in bits (≥2)
- NUM_REGS, 4, number of registers per bank (2..2**ADDR_W)
- ADDR_W, 2, width of all register address inputs

Ports:
- clk_i  input  1  clock, all state updates on rising edge
- rst_ni  input  1  reset; one clock; reset is asynchronous and active-low
- we_i  input  1  write enable
- waddr_i  input  ADDR_W  write register index
- wdata_i  input  DATA_W  write data
- raddr_a_i  input  ADDR_W  read port A index
- rdata_a_o  output  DATA_W  read port A data (combinational)
- raddr_b_i  input  ADDR_W  read port B index
- rdata_b_o  output  DATA_W  read port B data (combinational)
- step_en_i  input  1  step request
- step_addr_i  input  ADDR_W  register to step
- step_dec_i  input  1  0 = increment, 1 = decrement
- step_zero_o  output  1  registered: last applied step result was zero
- step_carry_o  output  1  registered: last applied step wrapped
- bank_swap_i  input  1  toggle active bank (shadow build only)
- bank_o  output  1  active bank index

## Operation
- Storage: NUM_REGS × DATA_W per bank. All registers, flags and bank_o reset to 0 asynchronously on rst_ni low. Normal operation resumes on the first rising clk_i edge after rst_ni goes high.
- Reads:
  - rdata_x_o = register[raddr_x_i] of the active bank, combinational.
  - raddr_x_i ≥ NUM_REGS returns 0.
  - No write bypass: a read in the same cycle as a write to that register returns the old value.
- Write: when we_i=1 and waddr_i < NUM_REGS, register[waddr_i] ← wdata_i at the edge. An out-of-range waddr_i is ignored.
- Step: when step_en_i=1 and step_addr_i < NUM_REGS, register ← register + 1 (step_dec_i=0) or − 1 (step_dec_i=1), modulo 2**DATA_W.
  - step_carry_o ← 1 when the step wraps: increment of all-ones → 0, or decrement of 0 → all-ones. Otherwise ← 0.
  - step_zero_o ← (result == 0).
- Flags update only on an applied step. In all other cycles they hold their value.
- Write/step collision:
  - we_i and step_en_i targeting the same valid register: the write wins, the step is discarded, and the flags hold.
  - Different registers: both apply in the same cycle.
- Out-of-range step_addr_i: no register change, flags hold.
- Reset asserted mid-operation overrides every pending write, step or swap.

## Timing
- Write latency 1 cycle: new value visible on the read ports after the clock edge.
- Step latency 1 cycle. Flags are valid in the same cycle as the updated register value.
- Back-to-back steps on one register each cycle are supported, e.g. 0xFE, 0xFF, 0x00 with carry asserted only at the 0x00 result.
- Read paths are purely combinational (address to data). No clocked read state.
- Swap (shadow build):
  - bank_o toggles at the edge where bank_swap_i=1.
  - Writes and steps in the swap cycle apply to the old (pre-toggle) bank.
  - Reads switch banks one cycle after the swap request.

## Configuration
- Macro CPU_REGFILE_SHADOW_EN.
- Defined:
  - Two banks of NUM_REGS registers.
  - bank_swap_i toggles bank_o.
  - All read, write and step ports address only the active bank; the inactive bank holds its contents.
  - Flags are shared and do not swap.
- Undefined:
  - One bank only.
  - bank_swap_i is ignored and bank_o is constant 0.
  - Port list is unchanged.

## Test plan
- Reset and write/read: assert rst_ni low → all reads 0, flags 0, bank_o 0. Write 0x5A to r1 and 0xC3 to r3, read A=r1, B=r3 → 0x5A / 0xC3 one cycle after each write; r0, r2 remain 0.
- Increment wrap: write 0xFE to r2, step inc twice → r2 = 0xFF (zero 0, carry 0), then 0x00 (zero 1, carry 1). Idle cycle → flags hold 1/1.
- Decrement wrap: r0 = 0x01, step dec → 0x00 (zero 1, carry 0). Step dec again → 0xFF (zero 0, carry 1).
- Collision: r1 = 0x10, same cycle we_i to r1 with 0x77 and step inc r1 → r1 = 0x77, flags unchanged. Same cycle write r1 = 0x20 and step r2 (0x05) → r1 = 0x20, r2 = 0x06.
- Range and async reset: write to index NUM_REGS → no register changes, read of that index = 0. Assert rst_ni between clock edges mid-sequence → all outputs 0 immediately, without waiting for a clock edge.
- Shadow (macro defined): write 0xAA to r0 in bank 0, swap, write 0x55 to r0 → reads 0x55 with bank_o = 1. Swap back → reads 0xAA. Swap and write r1 = 0x99 in the same cycle → 0x99 lands in the old bank. Macro undefined: swap → bank_o stays 0 and data is unchanged.
